// File: rtl/riscv_div_arbiter.sv
// Two-requester arbiter in front of a shared RISC-V divider.
// Round-robin grant, opcode screening, watchdog on the divider result.
module riscv_div_arbiter #(
  parameter int WATCHDOG_CYCLES = 40
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [31:0] req0_dividend_i,
  input  logic [31:0] req0_divisor_i,
  output logic        req0_ready_o,
  output logic        req0_resp_valid_o,
  output logic [31:0] req0_resp_value_o,
  output logic        req0_resp_err_o,
  input  logic        req1_valid_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [31:0] req1_dividend_i,
  input  logic [31:0] req1_divisor_i,
  output logic        req1_ready_o,
  output logic        req1_resp_valid_o,
  output logic [31:0] req1_resp_value_o,
  output logic        req1_resp_err_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic        div_valid_o,
  input  logic        div_busy_i,
  input  logic        div_valid_i,
  input  logic [31:0] div_result_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [5:0] WD_LAST = 6'(WATCHDOG_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic        ptr_q;
  logic        owner_q;
  logic [5:0]  cnt_q;
  logic [31:0] res_q;
  logic        err_q;
  logic        to_q;

  logic        gnt_any;
  logic        gnt_id;
  logic [31:0] sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] op_mask;
  logic        legal;
  logic        expire;

  // Pick the winner; a lone requester always wins, a tie uses the pointer.
  always_comb begin
    gnt_any = (req0_valid_i | req1_valid_i) & ~div_busy_i
            & (state_q == IDLE) & ~rst_i;
    gnt_id  = ptr_q;
    if (req0_valid_i && !req1_valid_i) begin
      gnt_id = 1'b0;
    end else if (req1_valid_i && !req0_valid_i) begin
      gnt_id = 1'b1;
    end
    sel_op  = gnt_id ? req1_opcode_i   : req0_opcode_i;
    sel_a   = gnt_id ? req1_dividend_i : req0_dividend_i;
    sel_b   = gnt_id ? req1_divisor_i  : req0_divisor_i;
    op_mask = sel_op & 32'hFE00_707F;
    legal   = (op_mask == 32'h0200_4033) | (op_mask == 32'h0200_5033)
            | (op_mask == 32'h0200_6033) | (op_mask == 32'h0200_7033);
    expire  = (state_q == WAIT) & ~div_valid_i & (cnt_q == WD_LAST);
  end

  // Next-state logic; a real result always beats a watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (gnt_any) state_d = legal ? ISSUE : RESP;
      ISSUE: state_d = WAIT;
      WAIT:  if (div_valid_i || expire) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, captured request, watchdog counter and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      owner_q        <= 1'b0;
      cnt_q          <= '0;
      res_q          <= '0;
      err_q          <= 1'b0;
      to_q           <= 1'b0;
      div_opcode_o   <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= expire;
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner_q        <= gnt_id;
            div_opcode_o   <= sel_op;
            div_dividend_o <= sel_a;
            div_divisor_o  <= sel_b;
            res_q          <= '0;
            err_q          <= ~legal;
          end
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + 6'd1;
          if (div_valid_i) begin
            res_q <= div_result_i;
            err_q <= 1'b0;
          end else if (expire) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        RESP: ptr_q <= ~owner_q;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; responses are zero unless valid.
  always_comb begin
    req0_ready_o      = gnt_any & ~gnt_id;
    req1_ready_o      = gnt_any & gnt_id;
    div_valid_o       = (state_q == ISSUE);
    req0_resp_valid_o = (state_q == RESP) & ~owner_q;
    req1_resp_valid_o = (state_q == RESP) & owner_q;
    req0_resp_value_o = req0_resp_valid_o ? res_q : '0;
    req1_resp_value_o = req1_resp_valid_o ? res_q : '0;
    req0_resp_err_o   = req0_resp_valid_o & err_q;
    req1_resp_err_o   = req1_resp_valid_o & err_q;
    timeout_o         = to_q;
  end

endmodule

// File: tb/tb_riscv_div_arbiter.sv
// Directed bench for riscv_div_arbiter.
// Divider results are supplied by hand with precomputed values.
module tb_riscv_div_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [31:0] req0_opcode_i, req0_dividend_i, req0_divisor_i;
  logic [31:0] req1_opcode_i, req1_dividend_i, req1_divisor_i;
  logic        req0_ready_o, req1_ready_o;
  logic        req0_resp_valid_o, req1_resp_valid_o;
  logic [31:0] req0_resp_value_o, req1_resp_value_o;
  logic        req0_resp_err_o, req1_resp_err_o;
  logic [31:0] div_opcode_o, div_dividend_o, div_divisor_o;
  logic        div_valid_o, div_busy_i, div_valid_i;
  logic [31:0] div_result_i;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk_i = ~clk_i;

  riscv_div_arbiter #(.WATCHDOG_CYCLES(40)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_opcode_i(req0_opcode_i),
    .req0_dividend_i(req0_dividend_i), .req0_divisor_i(req0_divisor_i),
    .req0_ready_o(req0_ready_o), .req0_resp_valid_o(req0_resp_valid_o),
    .req0_resp_value_o(req0_resp_value_o), .req0_resp_err_o(req0_resp_err_o),
    .req1_valid_i(req1_valid_i), .req1_opcode_i(req1_opcode_i),
    .req1_dividend_i(req1_dividend_i), .req1_divisor_i(req1_divisor_i),
    .req1_ready_o(req1_ready_o), .req1_resp_valid_o(req1_resp_valid_o),
    .req1_resp_value_o(req1_resp_value_o), .req1_resp_err_o(req1_resp_err_o),
    .div_opcode_o(div_opcode_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_valid_o(div_valid_o),
    .div_busy_i(div_busy_i), .div_valid_i(div_valid_i),
    .div_result_i(div_result_i), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    req0_valid_i = 1'b1; req0_opcode_i = 32'h0200_5033;
    req0_dividend_i = 32'd100; req0_divisor_i = 32'd7;
    req1_valid_i = 1'b0; req1_opcode_i = '0;
    req1_dividend_i = '0; req1_divisor_i = '0;
    div_busy_i = 1'b0; div_valid_i = 1'b0; div_result_i = '0;
    tick(); tick();
    chk("rst_ready0", 32'(req0_ready_o), 32'd0);
    chk("rst_div_valid", 32'(div_valid_o), 32'd0);
    chk("rst_div_opcode", div_opcode_o, 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_resp0", 32'(req0_resp_valid_o), 32'd0);

    // DIVU 100/7 from req0
    rst_i = 1'b0; #1;
    chk("divu_ready0", 32'(req0_ready_o), 32'd1);
    chk("divu_ready1", 32'(req1_ready_o), 32'd0);
    div_busy_i = 1'b1; #1;
    chk("busy_ready0", 32'(req0_ready_o), 32'd0);
    div_busy_i = 1'b0; #1;
    tick();
    req0_valid_i = 1'b0; #1;
    chk("divu_start", 32'(div_valid_o), 32'd1);
    chk("divu_opcode", div_opcode_o, 32'h0200_5033);
    chk("divu_dividend", div_dividend_o, 32'd100);
    chk("divu_divisor", div_divisor_o, 32'd7);
    chk("divu_ready_issue", 32'(req0_ready_o), 32'd0);
    tick();
    chk("divu_start_once", 32'(div_valid_o), 32'd0);
    tick(); tick();
    div_valid_i = 1'b1; div_result_i = 32'd14; #1;
    chk("divu_no_early_resp", 32'(req0_resp_valid_o), 32'd0);
    tick();
    div_valid_i = 1'b0; #1;
    chk("divu_resp0", 32'(req0_resp_valid_o), 32'd1);
    chk("divu_value", req0_resp_value_o, 32'd14);
    chk("divu_err", 32'(req0_resp_err_o), 32'd0);
    chk("divu_resp1", 32'(req1_resp_valid_o), 32'd0);
    tick();
    chk("divu_resp_end", 32'(req0_resp_valid_o), 32'd0);
    chk("divu_value_zero", req0_resp_value_o, 32'd0);
    chk("divu_opcode_hold", div_opcode_o, 32'h0200_5033);

    // reset in the middle of WAIT
    req1_valid_i = 1'b1; req1_opcode_i = 32'h0200_4033;
    req1_dividend_i = 32'd20; req1_divisor_i = 32'd3; #1;
    chk("mid_ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1; #1;
    chk("mid_rst_resp1", 32'(req1_resp_valid_o), 32'd0);
    chk("mid_rst_div_valid", 32'(div_valid_o), 32'd0);
    chk("mid_rst_dividend", div_dividend_o, 32'd0);
    chk("mid_rst_opcode", div_opcode_o, 32'd0);
    tick();
    rst_i = 1'b0;
    div_valid_i = 1'b1; div_result_i = 32'd6;
    tick();
    div_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_resp0", 32'(req0_resp_valid_o), 32'd0);
      chk("mid_no_resp1", 32'(req1_resp_valid_o), 32'd0);
      tick();
    end

    // simultaneous requests after reset: req0 wins, then req1
    req0_valid_i = 1'b1; req0_opcode_i = 32'h0200_6033;
    req0_dividend_i = 32'hFFFF_FFF9; req0_divisor_i = 32'd2;
    req1_valid_i = 1'b1; req1_opcode_i = 32'h0200_4033;
    req1_dividend_i = 32'd20; req1_divisor_i = 32'hFFFF_FFFD; #1;
    chk("pair_ready0", 32'(req0_ready_o), 32'd1);
    chk("pair_ready1", 32'(req1_ready_o), 32'd0);
    tick();
    req0_opcode_i = 32'h0200_5033;
    req0_dividend_i = 32'd9; req0_divisor_i = 32'd3; #1;
    chk("rem_dividend", div_dividend_o, 32'hFFFF_FFF9);
    chk("rem_start", 32'(div_valid_o), 32'd1);
    tick();
    div_valid_i = 1'b1; div_result_i = 32'hFFFF_FFFF;
    tick();
    div_valid_i = 1'b0; #1;
    chk("rem_resp0", 32'(req0_resp_valid_o), 32'd1);
    chk("rem_value", req0_resp_value_o, 32'hFFFF_FFFF);
    chk("rem_ready_resp", 32'(req0_ready_o | req1_ready_o), 32'd0);
    tick();
    chk("rr_ready1", 32'(req1_ready_o), 32'd1);
    chk("rr_ready0", 32'(req0_ready_o), 32'd0);
    tick();
    req1_valid_i = 1'b0; #1;
    chk("div_opcode", div_opcode_o, 32'h0200_4033);
    chk("div_divisor", div_divisor_o, 32'hFFFF_FFFD);
    tick();
    div_valid_i = 1'b1; div_result_i = 32'hFFFF_FFFA;
    tick();
    div_valid_i = 1'b0; #1;
    chk("div_resp1", 32'(req1_resp_valid_o), 32'd1);
    chk("div_value", req1_resp_value_o, 32'hFFFF_FFFA);
    chk("div_resp0_quiet", 32'(req0_resp_valid_o), 32'd0);
    chk("div_value0_quiet", req0_resp_value_o, 32'd0);
    tick();
    chk("back_ready0", 32'(req0_ready_o), 32'd1);
    tick();
    req0_valid_i = 1'b0;
    tick();
    div_valid_i = 1'b1; div_result_i = 32'd3;
    tick();
    div_valid_i = 1'b0; #1;
    chk("back_value", req0_resp_value_o, 32'd3);
    tick();

    // illegal opcode from req1
    req1_valid_i = 1'b1; req1_opcode_i = 32'h0000_0033; #1;
    chk("ill_ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0; #1;
    chk("ill_resp1", 32'(req1_resp_valid_o), 32'd1);
    chk("ill_value", req1_resp_value_o, 32'd0);
    chk("ill_err", 32'(req1_resp_err_o), 32'd1);
    chk("ill_no_start", 32'(div_valid_o), 32'd0);
    tick();
    chk("ill_resp_end", 32'(req1_resp_valid_o), 32'd0);
    chk("ill_err_end", 32'(req1_resp_err_o), 32'd0);

    // watchdog: divider never answers
    req0_valid_i = 1'b1; req0_opcode_i = 32'h0200_4033;
    req0_dividend_i = 32'd7; req0_divisor_i = 32'd1; #1;
    chk("wd_ready0", 32'(req0_ready_o), 32'd1);
    tick();
    req0_valid_i = 1'b0;
    n = 0;
    while (n < 100 && !req0_resp_valid_o) begin
      chk("wd_no_early_timeout", 32'(timeout_o), 32'd0);
      tick();
      n++;
    end
    chk("wd_latency", 32'(n), 32'd41);
    chk("wd_timeout", 32'(timeout_o), 32'd1);
    chk("wd_err", 32'(req0_resp_err_o), 32'd1);
    chk("wd_value", req0_resp_value_o, 32'd0);
    tick();
    chk("wd_timeout_end", 32'(timeout_o), 32'd0);

    // normal service after the timeout
    req1_valid_i = 1'b1; req1_opcode_i = 32'h0200_5033;
    req1_dividend_i = 32'd50; req1_divisor_i = 32'd5; #1;
    chk("post_ready1", 32'(req1_ready_o), 32'd1);
    tick();
    req1_valid_i = 1'b0; #1;
    chk("post_start", 32'(div_valid_o), 32'd1);
    tick();
    div_valid_i = 1'b1; div_result_i = 32'd10;
    tick();
    div_valid_i = 1'b0; #1;
    chk("post_resp1", 32'(req1_resp_valid_o), 32'd1);
    chk("post_value", req1_resp_value_o, 32'd10);
    chk("post_err", 32'(req1_resp_err_o), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_div_arbiter.md
RISCV_DIV_ARBITER -- requirements
Module: riscv_div_arbiter

Interface
REQ-001 SHALL have parameter WATCHDOG_CYCLES, default 40: maximum WAIT cycles before a forced error response.
REQ-002 SHALL have port clk_i  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have, for N=0,1, port reqN_valid_i  input  1: requester N holds a division request.
REQ-005 SHALL have, for N=0,1, port reqN_opcode_i  input  32: RISC-V instruction word.
REQ-006 SHALL have, for N=0,1, ports reqN_dividend_i and reqN_divisor_i  input  32: operands.
REQ-007 SHALL have, for N=0,1, port reqN_ready_o  output  1: request accepted this cycle.
REQ-008 SHALL have, for N=0,1, port reqN_resp_valid_o  output  1: one-cycle response pulse.
REQ-009 SHALL have, for N=0,1, port reqN_resp_value_o  output  32: quotient or remainder.
REQ-010 SHALL have, for N=0,1, port reqN_resp_err_o  output  1: response is illegal-opcode or timeout.
REQ-011 SHALL have ports div_opcode_o, div_dividend_o, div_divisor_o  output  32: registered divider operands.
REQ-012 SHALL have port div_valid_o  output  1: one-cycle divider start pulse.
REQ-013 SHALL have port div_busy_i  input  1: divider busy.
REQ-014 SHALL have port div_valid_i  input  1: divider result-valid pulse.
REQ-015 SHALL have port div_result_i  input  32: divider result.
REQ-016 SHALL have port timeout_o  output  1: one-cycle watchdog pulse.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: reqN_ready_o asserted only to the grant winner, combinationally, when at least one reqN_valid_i is high and div_busy_i is low; ready is never high outside IDLE.
REQ-019 Grant: single requester wins regardless of priority; if both are valid, the round-robin pointer picks the winner; pointer reset value selects req0.
REQ-020 The pointer SHALL move to the non-served requester on every RESP exit, including error responses.
REQ-021 On acceptance, opcode, dividend, divisor and owner id SHALL be registered; div_*_o hold these values from the cycle after acceptance until the next acceptance.
REQ-022 Legal opcodes: (opcode & 0xFE00707F) equals 0x02004033 (DIV), 0x02005033 (DIVU), 0x02006033 (REM) or 0x02007033 (REMU).
REQ-023 Legal opcode: IDLE->ISSUE; ISSUE asserts div_valid_o for exactly one cycle, then ->WAIT.
REQ-024 Illegal opcode: IDLE->RESP directly; div_valid_o never asserts; response carries value 0 and err=1.
REQ-025 WAIT: on div_valid_i, capture div_result_i and go ->RESP with err=0; a 6-bit counter starts at 0 on WAIT entry.
REQ-026 WAIT: if the counter reaches WATCHDOG_CYCLES without div_valid_i, go ->RESP with value 0 and err=1, and pulse timeout_o for one cycle.
REQ-027 RESP (one cycle): assert resp_valid/value/err to the owner only; the other requester's outputs stay 0; then ->IDLE.
REQ-028 div_valid_i outside WAIT SHALL be ignored; a simultaneous watchdog expiry and div_valid_i SHALL take the div_valid_i result.
REQ-029 reqN_resp_value_o and reqN_resp_err_o SHALL be 0 whenever reqN_resp_valid_o is 0.
REQ-030 Latency: acceptance at cycle T gives div_valid_o at T+1 and resp_valid one cycle after div_valid_i; an illegal opcode gives resp_valid at T+1.
REQ-031 Requesters SHALL hold reqN_valid_i and operands stable until ready; the block does not buffer unaccepted requests.

Reset
REQ-032 rst_i high SHALL immediately force IDLE, pointer=req0, counter=0, all outputs 0 and div_*_o registers 0.
REQ-033 Reset during ISSUE/WAIT/RESP SHALL discard the in-flight request with no response; the first grant after release follows REQ-019.

Verification
REQ-034 Reset asserted mid-WAIT -> all outputs 0 the same cycle; no resp_valid after release.
REQ-035 req0 DIVU (0x02005033) 100/7 at T -> div_valid_o at T+1 only; req0_resp_value_o=14, err=0, one cycle after div_valid_i.
REQ-036 Both valid from reset, REM -7/2 and DIV 20/-3 -> req0 served first (value 0xFFFFFFFF), then req1 (value 0xFFFFFFFA); a new simultaneous pair -> req1 served first.
REQ-037 req1 opcode 0x00000033 at T -> req1_resp_valid_o at T+1, value 0, err=1, div_valid_o stays 0.
REQ-038 Divider model never returns div_valid_i -> after 40 WAIT cycles, timeout_o and resp_valid pulse once with err=1; the next request is granted normally.
